// File: rtl/fma_pkg.sv
// Shared definitions for the FMA adder-stage sequencer and its helpers:
// the sequencer state encoding, the fixed request-to-result latency and
// the default width of the opaque request tag.
package fma_pkg;

  // Edges from accept to the first cycle with a valid result
  localparam int FMA_SEQ_LAT = 3;

  // Default width of the destination register / ROB id tag
  localparam int FMA_TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } fma_seq_state_t;

endpackage

// File: rtl/fma_seq_sign.sv
// Combinational sign logic for the FMA product/addend adder.
// Works out whether the addition is an effective subtraction, whether the
// selected adder mode produced a negative sum that must be inverted, and
// the sign of the final result. Kept separate so the rounding controller
// can reuse the same rules.
module fma_seq_sign (
  input  logic i_psign,
  input  logic i_zsign,
  input  logic i_kill,
  input  logic i_inc,
  input  logic i_negsum0,
  input  logic i_negsum1,
  input  logic i_neg,
  output logic o_effSub,
  output logic o_negNext,
  output logic o_resSign
);

  // Effective subtract inverts the addend; a negative sum can only arise
  // then, and the flag comes from whichever adder mode is selected. A
  // killed product leaves the addend sign as the result sign.
  always_comb begin
    o_effSub  = i_psign ^ i_zsign;
    o_negNext = o_effSub & (i_inc ? i_negsum1 : i_negsum0);
    o_resSign = i_kill ? i_zsign : (i_psign ^ i_neg);
  end

endmodule

// File: rtl/fma_add_seq.sv
// Multi-cycle sequencer for the FMA product/addend adder stage.
// One request is accepted at a time; the adder controls are held for an
// evaluate cycle, the adder sign flags are then resolved into the mux
// selects and a sum capture strobe, and the result sign/tag is offered to
// the normalizer over a valid/ready handshake.
// Optional macro FMA_SEQ_PERF_EN adds saturating perf_ops / perf_stall
// counters as extra output ports.
module fma_add_seq
  import fma_pkg::*;
#(
  parameter int TAG_W = FMA_TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_psign,
  input  logic             req_zsign,
  input  logic             req_killprod,
  input  logic             req_prodzero,
  input  logic             req_proddenorm,
  input  logic             req_inc,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  input  logic             negsum0,
  input  logic             negsum1,
  output logic             invz,
  output logic             killprod,
  output logic             proddenorm,
  output logic             selsum1,
  output logic             negsum,
  output logic             sum_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_sign,
  output logic [TAG_W-1:0] res_tag
`ifdef FMA_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  fma_seq_state_t r_state;
  fma_seq_state_t w_nextState;

  logic             r_psign;
  logic             r_zsign;
  logic             r_kill;
  logic             r_pden;
  logic             r_inc;
  logic [TAG_W-1:0] r_tag;
  logic             r_neg;
  logic             r_resSign;

  logic             w_accept;
  logic             w_effSub;
  logic             w_negNext;
  logic             w_resSign;

  fma_seq_sign u_sign (
    .i_psign   (r_psign),
    .i_zsign   (r_zsign),
    .i_kill    (r_kill),
    .i_inc     (r_inc),
    .i_negsum0 (negsum0),
    .i_negsum1 (negsum1),
    .i_neg     (r_neg),
    .o_effSub  (w_effSub),
    .o_negNext (w_negNext),
    .o_resSign (w_resSign)
  );

  // Handshake and adder-control outputs; controls come straight from the
  // registered request so they stay stable across EVAL, RESOLVE and DONE
  always_comb begin
    req_ready  = (r_state == IDLE) | ((r_state == DONE) & res_ready);
    w_accept   = req_valid & req_ready & ~flush;
    invz       = w_effSub;
    killprod   = r_kill;
    proddenorm = r_pden;
    selsum1    = r_inc;
    negsum     = (r_state == EVAL) ? 1'b0 : r_neg;
    sum_en     = (r_state == RESOLVE) & ~flush;
    res_valid  = (r_state == DONE) & ~flush;
    res_sign   = r_resSign;
    res_tag    = r_tag;
  end

  // Next-state logic; flush wins over everything, DONE can chain straight
  // into a new EVAL when the result and a new request hand off together
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_nextState = EVAL;
        EVAL:    w_nextState = RESOLVE;
        RESOLVE: w_nextState = DONE;
        DONE:    if (res_ready) w_nextState = w_accept ? EVAL : IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State register plus request capture, sign-flag sampling at the end of
  // EVAL and result-sign capture at the end of RESOLVE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_psign   <= 1'b0;
      r_zsign   <= 1'b0;
      r_kill    <= 1'b0;
      r_pden    <= 1'b0;
      r_inc     <= 1'b0;
      r_tag     <= '0;
      r_neg     <= 1'b0;
      r_resSign <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_psign <= req_psign;
        r_zsign <= req_zsign;
        r_kill  <= req_killprod | req_prodzero;
        r_pden  <= req_proddenorm;
        r_inc   <= req_inc;
        r_tag   <= req_tag;
      end
      if ((r_state == EVAL) && !flush) begin
        r_neg <= w_negNext;
      end
      if ((r_state == RESOLVE) && !flush) begin
        r_resSign <= w_resSign;
      end
    end
  end

`ifdef FMA_SEQ_PERF_EN
  logic [31:0] r_perfOps;
  logic [31:0] r_perfStall;

  // Saturating counters of completed results and backpressured DONE
  // cycles; only reset clears them so they survive a flush
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perfOps   <= '0;
      r_perfStall <= '0;
    end else begin
      if (res_valid && res_ready && (r_perfOps != 32'hFFFF_FFFF)) begin
        r_perfOps <= r_perfOps + 32'd1;
      end
      if ((r_state == DONE) && !res_ready && (r_perfStall != 32'hFFFF_FFFF)) begin
        r_perfStall <= r_perfStall + 32'd1;
      end
    end
  end

  assign perf_ops   = r_perfOps;
  assign perf_stall = r_perfStall;
`endif

endmodule

// File: tb/tb_fma_add_seq.sv
// Self-checking bench for fma_add_seq. Expected result sign/tag pairs are
// queued when a request is driven and compared when the sequencer offers
// its result.
module tb_fma_add_seq;
  import fma_pkg::*;

  localparam int TAG_W = 5;

  typedef struct packed {
    logic             sign;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_psign;
  logic             req_zsign;
  logic             req_killprod;
  logic             req_prodzero;
  logic             req_proddenorm;
  logic             req_inc;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             negsum0;
  logic             negsum1;
  logic             invz;
  logic             killprod;
  logic             proddenorm;
  logic             selsum1;
  logic             negsum;
  logic             sum_en;
  logic             res_valid;
  logic             res_ready;
  logic             res_sign;
  logic [TAG_W-1:0] res_tag;
`ifdef FMA_SEQ_PERF_EN
  logic [31:0]      perf_ops;
  logic [31:0]      perf_stall;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  fma_add_seq #(.TAG_W(TAG_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_psign      (req_psign),
    .req_zsign      (req_zsign),
    .req_killprod   (req_killprod),
    .req_prodzero   (req_prodzero),
    .req_proddenorm (req_proddenorm),
    .req_inc        (req_inc),
    .req_tag        (req_tag),
    .flush          (flush),
    .negsum0        (negsum0),
    .negsum1        (negsum1),
    .invz           (invz),
    .killprod       (killprod),
    .proddenorm     (proddenorm),
    .selsum1        (selsum1),
    .negsum         (negsum),
    .sum_en         (sum_en),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_sign       (res_sign),
    .res_tag        (res_tag)
`ifdef FMA_SEQ_PERF_EN
    ,
    .perf_ops       (perf_ops),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference sign rules
  function automatic logic modelNeg(input logic p, input logic z, input logic inc,
                                    input logic n0, input logic n1);
    return (p ^ z) & (inc ? n1 : n0);
  endfunction

  function automatic logic modelSign(input logic p, input logic z, input logic kill,
                                     input logic neg);
    return kill ? z : (p ^ neg);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveReq(input bit push, input logic p, input logic z, input logic kill,
                          input logic pzero, input logic pden, input logic inc,
                          input logic n0, input logic n1, input logic [TAG_W-1:0] tag);
    exp_t e;
    req_valid      = 1'b1;
    req_psign      = p;
    req_zsign      = z;
    req_killprod   = kill;
    req_prodzero   = pzero;
    req_proddenorm = pden;
    req_inc        = inc;
    req_tag        = tag;
    negsum0        = n0;
    negsum1        = n1;
    if (push) begin
      e.sign = modelSign(p, z, kill | pzero, modelNeg(p, z, inc, n0, n1));
      e.tag  = tag;
      sb.push_back(e);
    end
  endtask

  // Full single operation: EVAL, RESOLVE, DONE and hand-off back to IDLE
  task automatic runOp(input string name, input logic p, input logic z, input logic kill,
                       input logic pzero, input logic pden, input logic inc,
                       input logic n0, input logic n1, input logic [TAG_W-1:0] tag);
    logic       eNeg;
    logic [3:0] eCtl;
    logic [7:0] obs;
    logic [7:0] exp;
    eNeg = modelNeg(p, z, inc, n0, n1);
    eCtl = {p ^ z, kill | pzero, pden, inc};
    driveReq(1'b1, p, z, kill, pzero, pden, inc, n0, n1, tag);
    step();
    req_valid = 1'b0;

    obs = {invz, killprod, proddenorm, selsum1, negsum, sum_en, res_valid, req_ready};
    exp = {eCtl, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s_eval: actual=%b expected=%b", name, obs, exp);
    end

    step();
    obs = {invz, killprod, proddenorm, selsum1, negsum, sum_en, res_valid, req_ready};
    exp = {eCtl, eNeg, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s_resolve: actual=%b expected=%b", name, obs, exp);
    end

    step();
    obs = {invz, killprod, proddenorm, selsum1, negsum, sum_en, res_valid, req_ready};
    exp = {eCtl, eNeg, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s_done: actual=%b expected=%b", name, obs, exp);
    end

    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s_result: actual=%b expected=<empty queue>", name, {res_sign, res_tag});
    end else if ({res_sign, res_tag} !== sb[0]) begin
      failures++;
      $display("[TB] FAIL %s_result: actual=%b expected=%b", name, {res_sign, res_tag}, sb[0]);
    end

    res_ready = 1'b1;
    step();
    if (sb.size() > 0) void'(sb.pop_front());
    res_ready = 1'b0;
    #1;
    checks++;
    if ({res_valid, req_ready, sum_en} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL %s_idle: actual=%b expected=010", name, {res_valid, req_ready, sum_en});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({invz, killprod, proddenorm, selsum1, negsum, sum_en, res_valid, res_sign, res_tag,
         req_ready} !== {13'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_outputs: actual=%b expected=%b",
               {invz, killprod, proddenorm, selsum1, negsum, sum_en, res_valid, res_sign,
                res_tag, req_ready}, {13'd0, 1'b1});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_same_sign();
    runOp("same_sign", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
  endtask

  task automatic test_eff_sub();
    runOp("eff_sub", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
  endtask

  task automatic test_eff_sub_inc();
    runOp("eff_sub_inc", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd12);
  endtask

  task automatic test_kill();
    runOp("kill", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd17);
    runOp("prodzero", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd30);
  endtask

  task automatic test_back_to_back();
    driveReq(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
    step();
    req_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({res_valid, res_sign, res_tag} !== {1'b1, sb[0]}) begin
        failures++;
        $display("[TB] FAIL b2b_stall%0d: actual=%b expected=%b", i,
                 {res_valid, res_sign, res_tag}, {1'b1, sb[0]});
      end
      step();
    end
    driveReq(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd21);
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_ready: actual=%b expected=1", req_ready);
    end
    step();
    void'(sb.pop_front());
    req_valid = 1'b0;
    res_ready = 1'b0;
    #1;
    checks++;
    if ({sum_en, res_valid, req_ready} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL b2b_eval: actual=%b expected=000", {sum_en, res_valid, req_ready});
    end
    step();
    checks++;
    if ({sum_en, negsum} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL b2b_sum_en: actual=%b expected=11", {sum_en, negsum});
    end
    step();
    checks++;
    if ({res_valid, res_sign, res_tag} !== {1'b1, sb[0]}) begin
      failures++;
      $display("[TB] FAIL b2b_second: actual=%b expected=%b",
               {res_valid, res_sign, res_tag}, {1'b1, sb[0]});
    end
    res_ready = 1'b1;
    step();
    void'(sb.pop_front());
    res_ready = 1'b0;
  endtask

  task automatic test_flush();
    driveReq(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1;
    #1;
    checks++;
    if ({sum_en, res_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL flush_resolve: actual=%b expected=00", {sum_en, res_valid});
    end
    step();
    flush = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({req_ready, res_valid, sum_en} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL flush_idle: actual=%b expected=100", {req_ready, res_valid, sum_en});
    end
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_no_result: actual=%b expected=0", res_valid);
    end
    driveReq(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_blocks_accept: actual=%b expected=1", req_ready);
    end
    step();
    checks++;
    if (sum_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_no_sum_en: actual=%b expected=0", sum_en);
    end
  endtask

  task automatic test_reset_mid();
    driveReq(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd27);
    step();
    req_valid = 1'b0;
    step();
    step();
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_done: actual=%b expected=1", res_valid);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if ({invz, killprod, proddenorm, selsum1, negsum, sum_en, res_valid, res_sign, res_tag,
         req_ready} !== {13'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: actual=%b expected=%b",
               {invz, killprod, proddenorm, selsum1, negsum, sum_en, res_valid, res_sign,
                res_tag, req_ready}, {13'd0, 1'b1});
    end
    reset_n = 1'b1;
    sb.delete();
    step();
  endtask

  initial begin
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_psign      = 1'b0;
    req_zsign      = 1'b0;
    req_killprod   = 1'b0;
    req_prodzero   = 1'b0;
    req_proddenorm = 1'b0;
    req_inc        = 1'b0;
    req_tag        = '0;
    flush          = 1'b0;
    negsum0        = 1'b0;
    negsum1        = 1'b0;
    res_ready      = 1'b0;

    test_reset();
    test_same_sign();
    test_eff_sub();
    test_eff_sub_inc();
    test_kill();
    test_back_to_back();
    test_flush();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit so the run always ends on its own
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/fma_add_seq.md
Name: fma_add_seq

Overview:
- Multi-cycle sequencer for the FMA product/addend adder stage.
- Accepts one FMA add request at a time over valid/ready and holds the adder control (invz, killprod, proddenorm) stable for an evaluate cycle.
- Samples the adder's sign flags, then drives the sign/mode mux selects (negsum, selsum1) and a capture strobe for the downstream sum register.
- Presents the result sign and tag to the normalizer over a second valid/ready handshake.

Parameters:
- TAG_W, 5, width of the opaque request tag (destination register/ROB id) carried through to the result.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_psign  in  1  product sign (xs ^ ys)
- req_zsign  in  1  addend sign
- req_killprod  in  1  addend dominates product
- req_prodzero  in  1  product is exactly zero
- req_proddenorm  in  1  product denormal
- req_inc  in  1  request +1 compound-adder mode
- req_tag  in  TAG_W  request tag
- flush  in  1  abort in-flight operation
- negsum0  in  1  adder sign flag, +0 mode
- negsum1  in  1  adder sign flag, +1 mode
- invz  out  1  adder: negate addend
- killprod  out  1  adder: zero partial products
- proddenorm  out  1  adder: product denormal
- selsum1  out  1  adder: select +1 mode
- negsum  out  1  adder: invert selected sum
- sum_en  out  1  one-cycle capture strobe for the sum register
- res_valid  out  1  result sign/tag valid
- res_ready  in  1  downstream accepts result
- res_sign  out  1  result sign
- res_tag  out  TAG_W  result tag

Behaviour:
- Clock and reset: single clock clk; reset_n synchronous, active-low.
- States: IDLE, EVAL, RESOLVE, DONE (2-bit encoding).
- Reset (reset_n=0 at clk edge), effective at any time including mid-operation:
  - state=IDLE.
  - All registered fields cleared.
  - Outputs invz, killprod, proddenorm, selsum1, negsum, sum_en, res_valid, res_sign = 0; res_tag = 0.
  - req_ready=1 after reset.
- req_ready = (state==IDLE) | (state==DONE & res_ready).
- Handshake: accept when req_valid & req_ready.
  - On accept, register psign, zsign, killprod_in | prodzero, proddenorm, inc, tag; go to EVAL.
- EVAL (1 cycle):
  - invz = psign ^ zsign.
  - killprod = registered kill.
  - proddenorm = registered value.
  - selsum1 = inc.
  - negsum = 0.
  - At the end of the cycle, register neg = invz & (inc ? negsum1 : negsum0).
  - Go to RESOLVE.
- RESOLVE (1 cycle):
  - invz, killprod, proddenorm and selsum1 are held.
  - negsum = neg.
  - sum_en = 1.
  - Register res_sign = killprod ? zsign : (psign ^ neg).
  - Go to DONE.
- DONE:
  - res_valid = 1.
  - res_sign and res_tag are stable until res_ready.
  - Adder controls hold their last values; sum_en = 0.
  - On res_ready with no new accept: go to IDLE.
  - On res_ready & req_valid: accept in the same cycle and go to EVAL, giving back-to-back throughput of one op per 3 cycles.
- Latency: accept at edge N; sum_en high in cycle N+2; res_valid high from cycle N+3.
- Flush (lower priority than reset, higher than all else):
  - From any state, go to IDLE next edge.
  - sum_en and res_valid are forced 0 in the flush cycle.
  - A request presented with flush is not accepted, even though req_ready=1 in IDLE.
- res_valid must never drop without res_ready, except on flush or reset.
- Overflow of sign logic is impossible: all rules are single-bit.

Optional Feature:
- Macro FMA_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_ops[31:0] (completed res_valid & res_ready handshakes) and perf_stall[31:0] (cycles in DONE with res_ready=0).
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
  - Flush does not clear them.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fma_pkg:
  - state enum fma_seq_state_t {IDLE, EVAL, RESOLVE, DONE}
  - constant FMA_SEQ_LAT = 3
  - default tag width.
- One natural sub-module, fma_seq_sign: combinational eff-sub/neg/result-sign logic, reusable by the rounding controller.
- FSM and handshakes stay in the top module.

Test Plan:
- Same sign: psign=0, zsign=0, inc=0, negsum0=0.
  - Expected: invz=0 in EVAL; negsum=0 and sum_en=1 at N+2; res_valid at N+3 with res_sign=0.
- Effective subtract, negative: psign=0, zsign=1, inc=0, negsum0=1, negsum1=0.
  - Expected: invz=1; negsum=1 in RESOLVE; res_sign=1.
- Effective subtract with inc=1: negsum0=1, negsum1=0.
  - Expected: selsum1=1; negsum=0, because the flag is taken from the +1 mode; res_sign=psign.
- Kill: req_killprod=1, zsign=1, psign=0, negsum0=1.
  - Expected: killprod=1; res_sign=1 (zsign).
- Backpressure then back-to-back: hold res_ready=0 for 4 cycles, then assert it with req_valid=1.
  - Expected: res_sign and res_tag stable for all 4 cycles; the new request is accepted in the same cycle; the next sum_en follows 2 cycles later.
- Flush and reset:
  - flush in RESOLVE: no res_valid; IDLE next cycle.
  - reset_n=0 in DONE: all outputs 0 and req_ready=1 next cycle.
